// File: rtl/matrix_mul_pkg.sv
// Shared types and constants for the matrix multiplier RAM arbiter and its watchdog.
package matrix_mul_pkg;

  typedef enum logic [1:0] {
    S_HOST   = 2'd0,
    S_LAUNCH = 2'd1,
    S_RUN    = 2'd2,
    S_DRAIN  = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    ST_NONE    = 2'b00,
    ST_OK      = 2'b01,
    ST_ERR     = 2'b10,
    ST_TIMEOUT = 2'b11
  } status_t;

  // The control unit fetches its run header from this word.
  localparam int HDR_ADDR = 0;

endpackage

// File: rtl/matrix_watchdog.sv
// Run watchdog: counts enabled cycles since clear and flags the cycle whose count reaches the limit.
module matrix_watchdog #(
  parameter int to_w = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clear,
  input  logic            enable,
  input  logic [to_w-1:0] limit,
  output logic            expired
);

  logic [to_w-1:0] count_reg;
  logic [to_w-1:0] count_next;
  logic [to_w:0]   count_inc;
  logic            saturated;

  // count_reg holds completed cycles, so the current cycle is count_reg + 1.
  assign count_inc = {1'b0, count_reg} + (to_w + 1)'(1);
  assign expired   = enable && (limit != '0) && (count_inc == {1'b0, limit});
  assign saturated = (limit != '0) ? (count_reg == limit) : (count_reg == '1);

  always_comb begin
    count_next = count_reg;
    if (clear) begin
      count_next = '0;
    end else if (enable && !saturated) begin
      count_next = count_inc[to_w-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_next;
    end
  end

endmodule

// File: rtl/matrix_ram_arbiter.sv
// Owns the single-port matrix RAM: host loads it, the control unit runs on it under a watchdog.
module matrix_ram_arbiter
  import matrix_mul_pkg::*;
#(
  parameter int data_w    = 32,
  parameter int ram_d     = 512,
  parameter int ram_add_w = $clog2(ram_d),
  parameter int to_w      = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 host_req,
  input  logic                 host_we,
  input  logic [ram_add_w-1:0] host_addr,
  input  logic [data_w-1:0]    host_w_data,
  output logic                 host_ready,
  output logic [data_w-1:0]    host_r_data,
  output logic                 host_r_valid,
  input  logic                 host_start,
  input  logic [to_w-1:0]      timeout_limit,
  output logic                 host_busy,
  output logic                 host_done,
  output logic [1:0]           host_status,
  output logic                 cu_start,
  output logic                 cu_abort,
  input  logic                 cu_done,
  input  logic                 cu_err,
  input  logic                 cu_ram_we,
  input  logic [ram_add_w-1:0] cu_ram_addr,
  input  logic [data_w-1:0]    cu_ram_w_data,
  output logic [data_w-1:0]    cu_ram_r_data,
  output logic                 ram_we,
  output logic [ram_add_w-1:0] ram_addr,
  output logic [data_w-1:0]    ram_w_data,
  input  logic [data_w-1:0]    ram_r_data
);

  state_t          state_reg;
  state_t          state_next;
  status_t         status_reg;
  logic [to_w-1:0] limit_reg;
  logic            abort_hold_reg;
  logic            r_valid_reg;
  logic            start_accept;
  logic            run_active;
  logic            expired;
  logic            timeout_fire;
  logic            ram_we_mux;

  assign start_accept = (state_reg == S_HOST) && host_start;
  assign run_active   = (state_reg == S_RUN);
  // Control-unit completion outranks a simultaneous watchdog expiry.
  assign timeout_fire = run_active && expired && !cu_err && !cu_done;

  matrix_watchdog #(
    .to_w (to_w)
  ) u_watchdog (
    .clk     (clk),
    .rst     (rst),
    .clear   (start_accept),
    .enable  (run_active),
    .limit   (limit_reg),
    .expired (expired)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= S_HOST;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_HOST:   if (host_start) state_next = S_LAUNCH;
      S_LAUNCH: state_next = S_RUN;
      S_RUN:    if (cu_err || cu_done || expired) state_next = S_DRAIN;
      S_DRAIN:  state_next = S_HOST;
      default:  state_next = S_HOST;
    endcase
  end

  always_comb begin
    host_ready = 1'b0;
    host_busy  = 1'b1;
    host_done  = 1'b0;
    cu_start   = 1'b0;
    ram_we_mux = 1'b0;
    ram_addr   = cu_ram_addr;
    ram_w_data = cu_ram_w_data;
    case (state_reg)
      S_HOST: begin
        host_ready = 1'b1;
        host_busy  = 1'b0;
        ram_we_mux = host_req & host_we;
        ram_addr   = host_addr;
        ram_w_data = host_w_data;
      end
      S_LAUNCH: begin
        cu_start = 1'b1;
        ram_addr = ram_add_w'(HDR_ADDR);
      end
      S_RUN:   ram_we_mux = cu_ram_we & ~timeout_fire;
      S_DRAIN: host_done  = 1'b1;
      default: ;
    endcase
  end

  // Status, latched limit, read-valid and the post-reset abort hold.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      status_reg     <= ST_NONE;
      limit_reg      <= '0;
      abort_hold_reg <= 1'b1;
      r_valid_reg    <= 1'b0;
    end else begin
      abort_hold_reg <= 1'b0;
      r_valid_reg    <= (state_reg == S_HOST) && host_req && !host_we;
      if (start_accept) begin
        status_reg <= ST_NONE;
        limit_reg  <= timeout_limit;
      end else if (run_active) begin
        if (cu_err) begin
          status_reg <= ST_ERR;
        end else if (cu_done) begin
          status_reg <= ST_OK;
        end else if (expired) begin
          status_reg <= ST_TIMEOUT;
        end
      end
    end
  end

  assign ram_we        = ram_we_mux & rst;
  assign cu_abort      = abort_hold_reg | timeout_fire;
  assign host_status   = status_reg;
  assign host_r_valid  = r_valid_reg;
  assign host_r_data   = ram_r_data;
  assign cu_ram_r_data = ram_r_data;

endmodule

// File: tb/tb_matrix_ram_arbiter.sv
// Self-checking bench for matrix_ram_arbiter with a behavioural single-port RAM behind it.
module tb_matrix_ram_arbiter;

  localparam int DW = 32;
  localparam int AW = 9;
  localparam int TW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          host_req = 1'b0;
  logic          host_we = 1'b0;
  logic [AW-1:0] host_addr = '0;
  logic [DW-1:0] host_w_data = '0;
  logic          host_ready;
  logic [DW-1:0] host_r_data;
  logic          host_r_valid;
  logic          host_start = 1'b0;
  logic [TW-1:0] timeout_limit = '0;
  logic          host_busy;
  logic          host_done;
  logic [1:0]    host_status;
  logic          cu_start;
  logic          cu_abort;
  logic          cu_done = 1'b0;
  logic          cu_err = 1'b0;
  logic          cu_ram_we = 1'b0;
  logic [AW-1:0] cu_ram_addr = '0;
  logic [DW-1:0] cu_ram_w_data = '0;
  logic [DW-1:0] cu_ram_r_data;
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_w_data;
  logic [DW-1:0] ram_r_data;

  matrix_ram_arbiter #(
    .data_w (DW),
    .ram_d  (512),
    .to_w   (TW)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .host_req      (host_req),
    .host_we       (host_we),
    .host_addr     (host_addr),
    .host_w_data   (host_w_data),
    .host_ready    (host_ready),
    .host_r_data   (host_r_data),
    .host_r_valid  (host_r_valid),
    .host_start    (host_start),
    .timeout_limit (timeout_limit),
    .host_busy     (host_busy),
    .host_done     (host_done),
    .host_status   (host_status),
    .cu_start      (cu_start),
    .cu_abort      (cu_abort),
    .cu_done       (cu_done),
    .cu_err        (cu_err),
    .cu_ram_we     (cu_ram_we),
    .cu_ram_addr   (cu_ram_addr),
    .cu_ram_w_data (cu_ram_w_data),
    .cu_ram_r_data (cu_ram_r_data),
    .ram_we        (ram_we),
    .ram_addr      (ram_addr),
    .ram_w_data    (ram_w_data),
    .ram_r_data    (ram_r_data)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] mem [512];
  int unsigned   wr_count = 0;

  always @(posedge clk) begin
    if (ram_we) begin
      mem[ram_addr] <= ram_w_data;
      wr_count      <= wr_count + 1;
    end
    ram_r_data <= mem[ram_addr];
  end

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] exp;
  } vec_t;

  vec_t          vecs [7];
  logic [DW-1:0] exp_q [$];
  int            errors = 0;
  int            checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Advance one clock, then retire any read the DUT reports against the scoreboard.
  task automatic tick();
    logic [DW-1:0] e;
    @(posedge clk);
    #1;
    if (host_r_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rd_unexpected: host_r_valid=1 data=%h, no read outstanding", host_r_data);
      end else begin
        e = exp_q.pop_front();
        check("rd_data", host_r_data, e);
        $display("read  data=%h expected=%h", host_r_data, e);
      end
    end
  endtask

  task automatic host_access(input logic we, input logic [AW-1:0] addr,
                             input logic [DW-1:0] wdata, input logic [DW-1:0] exp);
    host_req    = 1'b1;
    host_we     = we;
    host_addr   = addr;
    host_w_data = wdata;
    if (!we) exp_q.push_back(exp);
    $display("host  we=%0d addr=%0d wdata=%h", we, addr, wdata);
    tick();
    host_req = 1'b0;
    host_we  = 1'b0;
  endtask

  task automatic launch(input logic [TW-1:0] limit);
    timeout_limit = limit;
    host_start    = 1'b1;
    tick();
    host_start = 1'b0;
    $display("run   start limit=%0d", limit);
  endtask

  int unsigned wr_base;
  int          bad_abort;
  int          bad_we;
  logic        saw_abort;
  logic        saw_done;

  initial begin
    vecs[0] = '{1'b1, 9'd0, 32'h0202_0202, 32'h0};
    vecs[1] = '{1'b0, 9'd0, 32'h0,         32'h0202_0202};
    vecs[2] = '{1'b1, 9'd5, 32'h0000_0055, 32'h0};
    vecs[3] = '{1'b1, 9'd9, 32'hDEAD_BEEF, 32'h0};
    vecs[4] = '{1'b0, 9'd9, 32'h0,         32'hDEAD_BEEF};
    vecs[5] = '{1'b0, 9'd5, 32'h0,         32'h0000_0055};
    vecs[6] = '{1'b0, 9'd0, 32'h0,         32'h0202_0202};

    // Reset state
    tick();
    tick();
    check("rst_busy", 32'(host_busy), 32'd0);
    check("rst_ready", 32'(host_ready), 32'd1);
    check("rst_abort", 32'(cu_abort), 32'd1);
    check("rst_status", 32'(host_status), 32'd0);
    check("rst_done", 32'(host_done), 32'd0);
    check("rst_cu_start", 32'(cu_start), 32'd0);
    check("rst_r_valid", 32'(host_r_valid), 32'd0);
    rst = 1'b1;
    #1;
    check("abort_hold", 32'(cu_abort), 32'd1);
    tick();
    check("abort_release", 32'(cu_abort), 32'd0);

    // Host write/read table
    for (int i = 0; i < 7; i++) begin
      host_access(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].exp);
    end
    tick();
    check("rd_latency_q_empty", 32'(exp_q.size()), 32'd0);
    check("host_wr_count", wr_count, 32'd3);

    // Launch, dropped host traffic, normal completion 100 cycles after start
    cu_ram_we   = 1'b1;
    cu_ram_addr = 9'd7;
    launch(16'd0);
    check("launch_cu_start", 32'(cu_start), 32'd1);
    check("launch_addr", 32'(ram_addr), 32'd0);
    check("launch_we", 32'(ram_we), 32'd0);
    check("launch_busy", 32'(host_busy), 32'd1);
    check("launch_ready", 32'(host_ready), 32'd0);
    cu_ram_we = 1'b0;
    tick();
    check("run_cu_start", 32'(cu_start), 32'd0);
    host_req    = 1'b1;
    host_we     = 1'b1;
    host_addr   = 9'd5;
    host_w_data = 32'h0000_0BAD;
    #1;
    check("run_host_we", 32'(ram_we), 32'd0);
    check("run_ready", 32'(host_ready), 32'd0);
    tick();
    host_we   = 1'b0;
    host_addr = 9'd9;
    tick();
    host_req = 1'b0;
    for (int i = 0; i < 96; i++) tick();
    cu_done = 1'b1;
    #1;
    check("ok_done_early", 32'(host_done), 32'd0);
    tick();
    cu_done = 1'b0;
    check("ok_done", 32'(host_done), 32'd1);
    check("ok_status", 32'(host_status), 32'd1);
    check("ok_drain_ready", 32'(host_ready), 32'd0);
    tick();
    check("ok_ready", 32'(host_ready), 32'd1);
    check("ok_done_clear", 32'(host_done), 32'd0);
    check("ok_busy", 32'(host_busy), 32'd0);
    $display("run   end status=%0d", host_status);
    host_access(1'b0, 9'd5, 32'h0, 32'h0000_0055);
    tick();
    check("run_wr_count", wr_count, 32'd3);

    // Error and done together; a start during the run is ignored
    launch(16'd0);
    check("err_status_clr", 32'(host_status), 32'd0);
    tick();
    host_start = 1'b1;
    tick();
    host_start = 1'b0;
    cu_err     = 1'b1;
    cu_done    = 1'b1;
    tick();
    cu_err  = 1'b0;
    cu_done = 1'b0;
    check("err_done", 32'(host_done), 32'd1);
    check("err_status", 32'(host_status), 32'd2);
    tick();
    check("err_done_single", 32'(host_done), 32'd0);
    check("err_ready", 32'(host_ready), 32'd1);
    tick();
    check("ignored_start_busy", 32'(host_busy), 32'd0);
    check("ignored_start_done", 32'(host_done), 32'd0);
    $display("run   end status=%0d", host_status);

    // Watchdog timeout on the 50th run cycle while the control unit keeps writing
    wr_base = wr_count;
    launch(16'd50);
    timeout_limit = 16'd0;
    cu_ram_we     = 1'b1;
    cu_ram_addr   = 9'd20;
    cu_ram_w_data = 32'h0000_0077;
    tick();
    bad_abort = 0;
    bad_we    = 0;
    for (int k = 1; k < 50; k++) begin
      if (cu_abort !== 1'b0) bad_abort++;
      if (ram_we !== 1'b1) bad_we++;
      tick();
    end
    check("to_early_abort", 32'(bad_abort), 32'd0);
    check("to_early_we", 32'(bad_we), 32'd0);
    check("to_abort", 32'(cu_abort), 32'd1);
    check("to_we", 32'(ram_we), 32'd0);
    tick();
    check("to_done", 32'(host_done), 32'd1);
    check("to_status", 32'(host_status), 32'd3);
    check("to_abort_clear", 32'(cu_abort), 32'd0);
    check("to_drain_we", 32'(ram_we), 32'd0);
    cu_ram_we = 1'b0;
    tick();
    check("to_ready", 32'(host_ready), 32'd1);
    check("to_wr_count", wr_count - wr_base, 32'd49);
    $display("run   end status=%0d", host_status);

    // Disabled watchdog over more than a full counter range
    launch(16'd0);
    saw_abort = 1'b0;
    saw_done  = 1'b0;
    for (int k = 0; k < 70000; k++) begin
      tick();
      if (cu_abort) saw_abort = 1'b1;
      if (host_done) saw_done = 1'b1;
    end
    check("nolimit_abort", 32'(saw_abort), 32'd0);
    check("nolimit_done", 32'(saw_done), 32'd0);
    check("nolimit_busy", 32'(host_busy), 32'd1);
    cu_done = 1'b1;
    tick();
    cu_done = 1'b0;
    check("nolimit_status", 32'(host_status), 32'd1);
    tick();
    $display("run   end status=%0d", host_status);

    // Reset in the middle of a run
    launch(16'd0);
    tick();
    cu_ram_we   = 1'b1;
    cu_ram_addr = 9'd30;
    #1;
    check("mid_we_before", 32'(ram_we), 32'd1);
    rst = 1'b0;
    #1;
    check("mid_we", 32'(ram_we), 32'd0);
    check("mid_busy", 32'(host_busy), 32'd0);
    check("mid_abort", 32'(cu_abort), 32'd1);
    tick();
    rst = 1'b1;
    #1;
    check("mid_abort_hold", 32'(cu_abort), 32'd1);
    check("mid_status", 32'(host_status), 32'd0);
    cu_ram_we = 1'b0;
    tick();
    check("mid_abort_release", 32'(cu_abort), 32'd0);
    check("mid_ready", 32'(host_ready), 32'd1);
    $display("reset mid-run done");

    check("final_q_empty", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
